// File: rtl/r_station.sv
// In-order reservation station: buffers decoded ALU micro-ops, issues one per
// cycle to the regfile, hands the issued op to the execute slot one cycle later,
// and replays an op whose flag write lost to an RMW flag write.
module r_station #(
    parameter int DEPTH = 4,
    parameter int OP_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    output logic                     id_ready,
    input  logic [2:0]               id_a,
    input  logic [2:0]               id_b,
    input  logic [2:0]               id_d,
    input  logic                     id_d_wr,
    input  logic                     id_sf_wr,
    input  logic [OP_W-1:0]          id_op,
    input  logic [15:0]              id_pc,
    output logic [2:0]               r_a_addr,
    output logic [2:0]               r_b_addr,
    output logic [15:0]              r_pc,
    output logic                     iss_valid,
    output logic                     ex_valid,
    output logic [OP_W-1:0]          alu_op,
    output logic                     alu_d_wr,
    output logic [2:0]               alu_d_adr,
    output logic                     alu_sf_wr,
    input  logic                     conflict_sf,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [2:0]      a;
        logic [2:0]      b;
        logic [2:0]      d;
        logic            d_wr;
        logic            sf_wr;
        logic [OP_W-1:0] op;
        logic [15:0]     pc;
    } uop_t;

    // Queue storage and control
    uop_t             mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    // Issue stage (combinational select) and replay holding register
    uop_t             iss_p0;
    logic             vld_p0;
    logic             from_head_p0;
    uop_t             rpl_p0;
    logic             rpl_vld_p0;

    // Execute stage register
    uop_t             ex_p1;
    logic             vld_p1;

    logic             push;
    logic             pop;
    logic             conflict;
    uop_t             id_uop;

    assign id_uop = '{a: id_a, b: id_b, d: id_d, d_wr: id_d_wr,
                      sf_wr: id_sf_wr, op: id_op, pc: id_pc};

    // A full queue refuses a push even if the head pops in the same cycle.
    assign id_ready = rst_n & (count < CNT_W'(DEPTH));
    assign push     = id_valid & id_ready;
    // A conflict only means something while the execute slot holds a real op.
    assign conflict = conflict_sf & vld_p1;
    // The head leaves only when it issued and the cycle was not squashed.
    assign pop      = from_head_p0 & ~conflict;

    // Issue select: pending replay first, then queue head, else an idle slot.
    always_comb begin
        iss_p0       = '0;
        vld_p0       = 1'b0;
        from_head_p0 = 1'b0;
        if (rst_n) begin
            if (rpl_vld_p0) begin
                iss_p0 = rpl_p0;
                vld_p0 = 1'b1;
            end else if (count != '0) begin
                iss_p0       = mem[rd_ptr];
                vld_p0       = 1'b1;
                from_head_p0 = 1'b1;
            end
        end
    end

    // Control state: pointers, occupancy, execute-valid and replay-valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            vld_p1     <= 1'b0;
            rpl_vld_p0 <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (conflict) begin
                // Failed op parks in replay; the execute slot becomes a bubble.
                rpl_vld_p0 <= 1'b1;
                vld_p1     <= 1'b0;
            end else begin
                vld_p1 <= vld_p0;
                if (vld_p0 && !from_head_p0) begin
                    rpl_vld_p0 <= 1'b0;
                end
            end
        end
    end

    // Datapath registers: queue writes, replay capture and execute load.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= id_uop;
        end
        if (conflict) begin
            rpl_p0 <= ex_p1;
        end else begin
            ex_p1 <= iss_p0;
        end
    end

    assign r_a_addr  = iss_p0.a;
    assign r_b_addr  = iss_p0.b;
    assign r_pc      = iss_p0.pc;
    assign iss_valid = vld_p0;

    assign ex_valid  = vld_p1;
    assign alu_op    = ex_p1.op;
    assign alu_d_adr = ex_p1.d;
    assign alu_d_wr  = rst_n & vld_p1 & ex_p1.d_wr;
    assign alu_sf_wr = rst_n & vld_p1 & ex_p1.sf_wr;

    assign occupancy = count;

endmodule

// File: tb/tb_r_station.sv
// Directed bench for r_station: per-cycle vector table for streaming and
// replay, plus hand sequences for fill, wrap and reset-during-replay.
module tb_r_station;

    localparam int DEPTH = 4;
    localparam int OP_W  = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic        id_ready;
    logic [2:0]  id_a, id_b, id_d;
    logic        id_d_wr, id_sf_wr;
    logic [OP_W-1:0] id_op;
    logic [15:0] id_pc;
    logic [2:0]  r_a_addr, r_b_addr;
    logic [15:0] r_pc;
    logic        iss_valid, ex_valid;
    logic [OP_W-1:0] alu_op;
    logic        alu_d_wr;
    logic [2:0]  alu_d_adr;
    logic        alu_sf_wr;
    logic        conflict_sf;
    logic [2:0]  occupancy;

    int n_chk  = 0;
    int n_pass = 0;
    logic [OP_W-1:0] exec_q[$];

    r_station #(.DEPTH(DEPTH), .OP_W(OP_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
        .id_a(id_a), .id_b(id_b), .id_d(id_d), .id_d_wr(id_d_wr),
        .id_sf_wr(id_sf_wr), .id_op(id_op), .id_pc(id_pc),
        .r_a_addr(r_a_addr), .r_b_addr(r_b_addr), .r_pc(r_pc),
        .iss_valid(iss_valid), .ex_valid(ex_valid), .alu_op(alu_op),
        .alu_d_wr(alu_d_wr), .alu_d_adr(alu_d_adr), .alu_sf_wr(alu_sf_wr),
        .conflict_sf(conflict_sf), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Record every op that leaves the execute slot without a conflict.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ex_valid === 1'b1 && conflict_sf === 1'b0)
            exec_q.push_back(alu_op);
    end

    typedef struct {
        logic        vin;
        logic [2:0]  d;
        logic        dwr;
        logic        sf;
        logic [4:0]  op;
        logic [15:0] pc;
        logic        conf;
        logic        e_rdy;
        logic        e_iss;
        logic [15:0] e_rpc;
        logic [2:0]  e_ra;
        logic        e_exv;
        logic [2:0]  e_dadr;
        logic        e_dwr;
        logic        e_sf;
        logic [2:0]  e_occ;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic drive(input logic vin, input logic [2:0] d, input logic dwr,
                         input logic sf, input logic [4:0] op, input logic [15:0] pc,
                         input logic conf);
        id_valid    = vin;
        id_d        = d;
        id_a        = d ^ 3'b111;
        id_b        = d;
        id_d_wr     = dwr;
        id_sf_wr    = sf;
        id_op       = op;
        id_pc       = pc;
        conflict_sf = conf;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 1'b0, 1'b0, 5'd0, 16'h0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run idle cycles until queue and execute slot are empty, bounded.
    task automatic drain(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            idle();
            #1;
            if (occupancy == 3'd0 && !ex_valid && !iss_valid) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk(name, {31'd0, done}, 32'd1);
    endtask

    vec_t vt[13];

    initial begin
        //          vin d    dwr  sf   op   pc        conf rdy  iss  rpc       ra   exv  dadr dwr  sf   occ
        vt[0]  = '{1'b1,3'd1,1'b1,1'b0,5'd1,16'h0100,1'b0,1'b1,1'b0,16'h0000,3'd0,1'b0,3'd0,1'b0,1'b0,3'd0};
        vt[1]  = '{1'b1,3'd2,1'b1,1'b0,5'd2,16'h0101,1'b0,1'b1,1'b1,16'h0100,3'd6,1'b0,3'd0,1'b0,1'b0,3'd1};
        vt[2]  = '{1'b1,3'd4,1'b1,1'b0,5'd3,16'h0102,1'b0,1'b1,1'b1,16'h0101,3'd5,1'b1,3'd1,1'b1,1'b0,3'd1};
        vt[3]  = '{1'b0,3'd0,1'b0,1'b0,5'd0,16'h0000,1'b0,1'b1,1'b1,16'h0102,3'd3,1'b1,3'd2,1'b1,1'b0,3'd1};
        vt[4]  = '{1'b0,3'd0,1'b0,1'b0,5'd0,16'h0000,1'b0,1'b1,1'b0,16'h0000,3'd0,1'b1,3'd4,1'b1,1'b0,3'd0};
        vt[5]  = '{1'b0,3'd0,1'b0,1'b0,5'd0,16'h0000,1'b0,1'b1,1'b0,16'h0000,3'd0,1'b0,3'd0,1'b0,1'b0,3'd0};
        vt[6]  = '{1'b1,3'd3,1'b1,1'b1,5'd4,16'h0200,1'b0,1'b1,1'b0,16'h0000,3'd0,1'b0,3'd0,1'b0,1'b0,3'd0};
        vt[7]  = '{1'b1,3'd5,1'b0,1'b0,5'd5,16'h0201,1'b0,1'b1,1'b1,16'h0200,3'd4,1'b0,3'd0,1'b0,1'b0,3'd1};
        vt[8]  = '{1'b0,3'd0,1'b0,1'b0,5'd0,16'h0000,1'b1,1'b1,1'b1,16'h0201,3'd2,1'b1,3'd3,1'b1,1'b1,3'd1};
        vt[9]  = '{1'b0,3'd0,1'b0,1'b0,5'd0,16'h0000,1'b0,1'b1,1'b1,16'h0200,3'd4,1'b0,3'd0,1'b0,1'b0,3'd1};
        vt[10] = '{1'b0,3'd0,1'b0,1'b0,5'd0,16'h0000,1'b0,1'b1,1'b1,16'h0201,3'd2,1'b1,3'd3,1'b1,1'b1,3'd1};
        vt[11] = '{1'b0,3'd0,1'b0,1'b0,5'd0,16'h0000,1'b0,1'b1,1'b0,16'h0000,3'd0,1'b1,3'd5,1'b0,1'b0,3'd0};
        vt[12] = '{1'b0,3'd0,1'b0,1'b0,5'd0,16'h0000,1'b0,1'b1,1'b0,16'h0000,3'd0,1'b0,3'd0,1'b0,1'b0,3'd0};

        // Reset held two cycles with decode offering an op
        rst_n = 1'b0;
        drive(1'b1, 3'd7, 1'b1, 1'b1, 5'd31, 16'h0300, 1'b0);
        #1;
        chk("rst_ready_c0", {31'd0, id_ready}, 32'd0);
        chk("rst_dwr_c0", {31'd0, alu_d_wr}, 32'd0);
        chk("rst_iss_c0", {31'd0, iss_valid}, 32'd0);
        tick();
        chk("rst_ready_c1", {31'd0, id_ready}, 32'd0);
        chk("rst_dwr_c1", {31'd0, alu_d_wr}, 32'd0);
        chk("rst_occ_c1", {29'd0, occupancy}, 32'd0);
        chk("rst_rpc_c1", {16'd0, r_pc}, 32'd0);
        chk("rst_ra_c1", {29'd0, r_a_addr}, 32'd0);
        tick();
        rst_n = 1'b1;
        idle();
        #1;
        chk("rel_ready", {31'd0, id_ready}, 32'd1);
        chk("rel_occ", {29'd0, occupancy}, 32'd0);
        tick();

        // Streaming and single replay, cycle by cycle
        exec_q.delete();
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].vin, vt[i].d, vt[i].dwr, vt[i].sf, vt[i].op, vt[i].pc, vt[i].conf);
            #1;
            chk($sformatf("v%0d_ready", i), {31'd0, id_ready}, {31'd0, vt[i].e_rdy});
            chk($sformatf("v%0d_iss", i), {31'd0, iss_valid}, {31'd0, vt[i].e_iss});
            chk($sformatf("v%0d_rpc", i), {16'd0, r_pc}, {16'd0, vt[i].e_rpc});
            chk($sformatf("v%0d_ra", i), {29'd0, r_a_addr}, {29'd0, vt[i].e_ra});
            chk($sformatf("v%0d_exv", i), {31'd0, ex_valid}, {31'd0, vt[i].e_exv});
            if (vt[i].e_exv)
                chk($sformatf("v%0d_dadr", i), {29'd0, alu_d_adr}, {29'd0, vt[i].e_dadr});
            chk($sformatf("v%0d_adwr", i), {31'd0, alu_d_wr}, {31'd0, vt[i].e_dwr});
            chk($sformatf("v%0d_asf", i), {31'd0, alu_sf_wr}, {31'd0, vt[i].e_sf});
            chk($sformatf("v%0d_occ", i), {29'd0, occupancy}, {29'd0, vt[i].e_occ});
            tick();
        end
        chk("tbl_exec_cnt", exec_q.size(), 32'd5);
        for (int i = 0; i < 5 && i < exec_q.size(); i++)
            chk($sformatf("tbl_exec%0d", i), {27'd0, exec_q[i]}, i + 1);

        // Fill: conflicts held high stop the head from popping
        exec_q.delete();
        begin
            logic [15:0] f_rpc[8] = '{16'h0, 16'h400, 16'h401, 16'h400, 16'h401, 16'h400, 16'h401, 16'h402};
            logic [2:0]  f_occ[8] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd3};
            logic        f_rdy[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
            logic        f_exv[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
            for (int k = 0; k < 8; k++) begin
                int p;
                p = (k < 5) ? k : 5;
                drive(1'b1, 3'(p), 1'b1, 1'b1, 5'(8 + p), 16'h0400 + 16'(p), (k < 6) ? 1'b1 : 1'b0);
                #1;
                chk($sformatf("full%0d_ready", k), {31'd0, id_ready}, {31'd0, f_rdy[k]});
                chk($sformatf("full%0d_occ", k), {29'd0, occupancy}, {29'd0, f_occ[k]});
                if (k > 0)
                    chk($sformatf("full%0d_rpc", k), {16'd0, r_pc}, {16'd0, f_rpc[k]});
                chk($sformatf("full%0d_exv", k), {31'd0, ex_valid}, {31'd0, f_exv[k]});
                tick();
            end
        end
        drain("full_drain");
        chk("full_exec_cnt", exec_q.size(), 32'd6);
        for (int i = 0; i < 6 && i < exec_q.size(); i++)
            chk($sformatf("full_exec%0d", i), {27'd0, exec_q[i]}, 8 + i);
        tick();

        // Wrap: ten ops pushed back to back
        exec_q.delete();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 3'(k), 1'b1, 1'b0, 5'(16 + k), 16'h0500 + 16'(k), 1'b0);
            #1;
            chk($sformatf("wrap%0d_occ_max", k), {31'd0, occupancy <= 3'd4}, 32'd1);
            chk($sformatf("wrap%0d_ready", k), {31'd0, id_ready}, 32'd1);
            tick();
        end
        drain("wrap_drain");
        chk("wrap_exec_cnt", exec_q.size(), 32'd10);
        for (int i = 0; i < 10 && i < exec_q.size(); i++)
            chk($sformatf("wrap_exec%0d", i), {27'd0, exec_q[i]}, 16 + i);
        tick();

        // Reset the cycle after a conflict
        exec_q.delete();
        drive(1'b1, 3'd6, 1'b1, 1'b1, 5'd26, 16'h0600, 1'b0);
        tick();
        idle();
        tick();
        drive(1'b0, 3'd0, 1'b0, 1'b0, 5'd0, 16'h0, 1'b1);
        #1;
        chk("mr_exv_before", {31'd0, ex_valid}, 32'd1);
        tick();
        rst_n = 1'b0;
        idle();
        #1;
        chk("mr_rst_iss", {31'd0, iss_valid}, 32'd0);
        chk("mr_rst_dwr", {31'd0, alu_d_wr}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            idle();
            #1;
            chk($sformatf("mr_post%0d_iss", k), {31'd0, iss_valid}, 32'd0);
            chk($sformatf("mr_post%0d_exv", k), {31'd0, ex_valid}, 32'd0);
            chk($sformatf("mr_post%0d_dwr", k), {31'd0, alu_d_wr}, 32'd0);
            tick();
        end
        drive(1'b1, 3'd2, 1'b1, 1'b0, 5'd27, 16'h0610, 1'b0);
        #1;
        chk("mr_new_iss_same", {31'd0, iss_valid}, 32'd0);
        tick();
        idle();
        #1;
        chk("mr_new_rpc", {16'd0, r_pc}, 32'h0610);
        tick();
        drain("mr_drain");
        chk("mr_exec_cnt", exec_q.size(), 32'd1);
        if (exec_q.size() > 0)
            chk("mr_exec0", {27'd0, exec_q[0]}, 32'd27);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
